// File: rtl/affine_addr_gen.sv
// affine_addr_gen: N-dimensional affine address walker (dim 0 innermost).
// Emits offset + sum(idx[d]*stride[d]) on a valid/ready stream, one per beat.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   start, abort         launch a job (IDLE only) / cancel a running job
//   cfg_offset           base address
//   cfg_extent           per-dim trip counts, dim d at [d*CNT_W +: CNT_W]
//   cfg_stride           per-dim signed strides, dim d at [d*ADDR_W +: ADDR_W]
//   addr, addr_valid     address stream, accepted when addr_ready is high
//   addr_last, dim_wrap  final-beat flag and per-dim loop-close flags
//   busy, done           job running / one-cycle completion pulse
module affine_addr_gen #(
    parameter int DIMS   = 3,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_W-1:0]      cfg_offset,
    input  logic [DIMS*CNT_W-1:0]  cfg_extent,
    input  logic [DIMS*ADDR_W-1:0] cfg_stride,
    output logic [ADDR_W-1:0]      addr,
    output logic                   addr_valid,
    input  logic                   addr_ready,
    output logic                   addr_last,
    output logic [DIMS-1:0]        dim_wrap,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  ext_q    [DIMS];
    logic [ADDR_W-1:0] stride_q [DIMS];
    logic [CNT_W-1:0]  idx_q    [DIMS];
    logic [ADDR_W-1:0] base_q   [DIMS];
    logic              done_q;

    logic [DIMS-1:0]   at_end;
    logic [DIMS-1:0]   raw_wrap;
    logic [DIMS-1:0]   step;
    logic [ADDR_W-1:0] nb;
    logic              acc;
    logic              run;
    logic              beat;
    logic              last;
    logic              empty;

    assign run  = (state == RUN);
    assign beat = run & addr_ready;
    assign last = raw_wrap[DIMS-1];

    // step[d] marks the lowest dim not at its end (the one that advances);
    // raw_wrap[d] is the running AND of at_end[0..d].
    always_comb begin
        at_end   = '0;
        raw_wrap = '0;
        step     = '0;
        nb       = '0;
        acc      = 1'b1;
        for (int d = 0; d < DIMS; d++) begin
            at_end[d]   = (idx_q[d] == ext_q[d] - CNT_W'(1));
            step[d]     = acc & ~at_end[d];
            acc         = acc & at_end[d];
            raw_wrap[d] = acc;
        end
        for (int d = 0; d < DIMS; d++) begin
            if (step[d]) begin
                nb = base_q[d] + stride_q[d];
            end
        end
    end

    always_comb begin
        empty = 1'b0;
        for (int d = 0; d < DIMS; d++) begin
            if (cfg_extent[d*CNT_W +: CNT_W] == '0) begin
                empty = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && !empty) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort || (beat && last)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
            for (int d = 0; d < DIMS; d++) begin
                ext_q[d]    <= '0;
                stride_q[d] <= '0;
                idx_q[d]    <= '0;
                base_q[d]   <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (!run) begin
                if (start) begin
                    done_q <= empty;
                    for (int d = 0; d < DIMS; d++) begin
                        ext_q[d]    <= cfg_extent[d*CNT_W +: CNT_W];
                        stride_q[d] <= cfg_stride[d*ADDR_W +: ADDR_W];
                        idx_q[d]    <= '0;
                        base_q[d]   <= cfg_offset;
                    end
                end
            end else if (!abort && beat) begin
                if (last) begin
                    done_q <= 1'b1;
                end else begin
                    // Dims below the advancing one restart at its new base.
                    for (int d = 0; d < DIMS; d++) begin
                        if (step[d]) begin
                            idx_q[d]  <= idx_q[d] + CNT_W'(1);
                            base_q[d] <= nb;
                        end else if (raw_wrap[d]) begin
                            idx_q[d]  <= '0;
                            base_q[d] <= nb;
                        end
                    end
                end
            end
        end
    end

    assign addr       = base_q[0];
    assign addr_valid = run;
    assign busy       = run;
    assign done       = done_q;
    assign dim_wrap   = run ? raw_wrap : '0;
    assign addr_last  = &dim_wrap;

endmodule

// File: tb/tb_affine_addr_gen.sv
// tb_affine_addr_gen: randomized self-checking bench for affine_addr_gen.
// Expected beats come from a nested-loop reference built per job.
module tb_affine_addr_gen;

    localparam int DIMS = 3;
    localparam int AW   = 16;
    localparam int CW   = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [AW-1:0]        cfg_offset;
    logic [DIMS*CW-1:0]   cfg_extent;
    logic [DIMS*AW-1:0]   cfg_stride;
    logic [AW-1:0]        addr;
    logic                 addr_valid;
    logic                 addr_ready;
    logic                 addr_last;
    logic [DIMS-1:0]      dim_wrap;
    logic                 busy;
    logic                 done;

    affine_addr_gen #(.DIMS(DIMS), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_offset (cfg_offset),
        .cfg_extent (cfg_extent),
        .cfg_stride (cfg_stride),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr_last  (addr_last),
        .dim_wrap   (dim_wrap),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0]   a;
        logic [DIMS-1:0] w;
        logic            l;
    } beat_t;

    beat_t q[$];

    // Reference: plain nested loops over the iteration space.
    task automatic build(input logic [AW-1:0] off, input int e0, input int e1,
                         input int e2, input logic [AW-1:0] s0,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        beat_t b;
        logic [31:0] t;
        q.delete();
        for (int i2 = 0; i2 < e2; i2++)
            for (int i1 = 0; i1 < e1; i1++)
                for (int i0 = 0; i0 < e0; i0++) begin
                    t = 32'(off) + 32'(i0) * 32'(s0) + 32'(i1) * 32'(s1)
                        + 32'(i2) * 32'(s2);
                    b.a    = t[AW-1:0];
                    b.w[0] = (i0 == e0 - 1);
                    b.w[1] = b.w[0] && (i1 == e1 - 1);
                    b.w[2] = b.w[1] && (i2 == e2 - 1);
                    b.l    = b.w[2];
                    q.push_back(b);
                end
    endtask

    // rmode: 0 always ready, 1 random, 2 pattern 1,0,0
    task automatic run_job(input logic [AW-1:0] off, input int e0,
                           input int e1, input int e2,
                           input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                           input logic [AW-1:0] s2, input int rmode,
                           input int abort_at, input int busy_start);
        int n;
        int beats;
        int cyc;
        logic stalled;
        logic rdy;
        logic [AW-1:0] sa;
        logic [DIMS-1:0] sw;
        beat_t b;
        build(off, e0, e1, e2, s0, s1, s2);
        n = q.size();
        @(negedge clk);
        cfg_offset = off;
        cfg_extent = {CW'(e2), CW'(e1), CW'(e0)};
        cfg_stride = {s2, s1, s0};
        start = 1'b1;
        abort = 1'b0;
        addr_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cfg_offset = AW'($urandom);
        cfg_extent = {CW'($urandom_range(1, 5)), CW'($urandom_range(1, 5)),
                      CW'($urandom_range(1, 5))};
        cfg_stride = {AW'($urandom), AW'($urandom), AW'($urandom)};
        if (n == 0) begin
            check("empty_done", done, 1);
            check("empty_valid", addr_valid, 0);
            @(negedge clk);
            check("empty_done_low", done, 0);
            check("empty_valid_low", addr_valid, 0);
            return;
        end
        check("start_busy", busy, 1);
        stalled = 1'b0;
        beats = 0;
        cyc = 0;
        while (q.size() > 0 && cyc < 400) begin
            check("valid", addr_valid, 1);
            if (stalled) begin
                check("stall_addr", addr, sa);
                check("stall_wrap", dim_wrap, sw);
            end
            start = (cyc == busy_start);
            if (abort_at >= 0 && beats == abort_at) begin
                abort = 1'b1;
                addr_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                check("abort_valid", addr_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                @(negedge clk);
                check("abort_done_late", done, 0);
                q.delete();
                return;
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc % 3 == 0);
            endcase
            addr_ready = rdy;
            if (rdy) begin
                b = q.pop_front();
                check("addr", addr, b.a);
                check("dim_wrap", dim_wrap, b.w);
                check("addr_last", addr_last, b.l);
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                sa = addr;
                sw = dim_wrap;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        addr_ready = 1'b0;
        if (q.size() > 0) begin
            check("timeout", 0, 1);
            q.delete();
            return;
        end
        check("beat_count", beats, n);
        check("done", done, 1);
        check("end_busy", busy, 0);
        check("end_valid", addr_valid, 0);
        check("end_wrap", dim_wrap, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        addr_ready = 1'b0;
        cfg_offset = '0;
        cfg_extent = '0;
        cfg_stride = '0;
        #12;
        check("rst_addr", addr, 0);
        check("rst_valid", addr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wrap", dim_wrap, 0);
        @(negedge clk);
        rst = 1'b0;

        run_job(16'h0100, 3, 2, 1, 16'd1, 16'd16, 16'd0, 0, -1, -1);
        run_job(16'h0100, 3, 2, 1, 16'd1, 16'd16, 16'd0, 2, -1, 3);
        run_job(16'h0001, 4, 1, 1, 16'hFFFF, 16'd0, 16'd0, 0, -1, -1);
        run_job(16'h0040, 3, 0, 1, 16'd1, 16'd8, 16'd0, 0, -1, -1);
        run_job(16'h0055, 1, 1, 1, 16'd7, 16'd9, 16'd3, 0, -1, -1);
        run_job(16'h0200, 3, 3, 1, 16'd1, 16'd8, 16'd0, 0, 2, -1);
        run_job(16'h0200, 3, 3, 1, 16'd1, 16'd8, 16'd0, 0, -1, -1);

        for (int j = 0; j < 30; j++) begin
            run_job(AW'($urandom),
                    ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4),
                    $urandom_range(1, 4), $urandom_range(1, 3),
                    AW'($urandom), AW'($urandom), AW'($urandom),
                    1, ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4) : -1,
                    $urandom_range(0, 6));
        end

        @(negedge clk);
        cfg_offset = 16'h0300;
        cfg_extent = {CW'(1), CW'(3), CW'(3)};
        cfg_stride = {16'd0, 16'd8, 16'd1};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        addr_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_addr", addr, 0);
        check("midrst_valid", addr_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_last", addr_last, 0);
        check("midrst_wrap", dim_wrap, 0);
        @(negedge clk);
        rst = 1'b0;
        addr_ready = 1'b0;
        @(negedge clk);
        check("postrst_valid", addr_valid, 0);

        run_job(16'h0300, 3, 3, 1, 16'd1, 16'd8, 16'd0, 1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/affine_addr_gen.md
# affine_addr_gen

Parametrised N-dimensional affine address generator: the successor to the fixed two-level x/y counter chain. It walks up to DIMS nested loops with runtime extents and signed strides and emits `offset + Σ idx[d]*stride[d]` on a valid/ready stream. It sits between the configuration registers and a memory port or buffer read/write port. It adds a start/done job model, back-pressure, abort, empty-job handling and per-dimension wrap flags.

## Interface
- `DIMS`, default 3: loop dimensions, 1..4; dim 0 is innermost.
- `ADDR_W`, default 16: address and stride width.
- `CNT_W`, default 16: extent and index width.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch a job; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a running job.
- `cfg_offset`  in  ADDR_W  base address.
- `cfg_extent`  in  DIMS*CNT_W  per-dim trip count; dim d at bits [d*CNT_W +: CNT_W].
- `cfg_stride`  in  DIMS*ADDR_W  per-dim stride, two's complement; same packing.
- `addr`  out  ADDR_W  current address.
- `addr_valid`  out  1  `addr` is valid.
- `addr_ready`  in  1  consumer accepts `addr`.
- `addr_last`  out  1  the current `addr` is the final one of the job.
- `dim_wrap`  out  DIMS  bit d set when idx[0..d] are all at extent-1 (the current beat closes loop d).
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at job completion.

## Operation
- **States.** IDLE and RUN.
- **Reset values.** All outputs 0, state IDLE, indices 0.
- **IDLE + start.** Latch `cfg_*` into shadow registers; later cfg changes have no effect on the running job.
  - If any extent is 0 (empty job): stay in IDLE and pulse `done` next cycle. `addr_valid` never rises.
  - Otherwise: go to RUN. Set idx[d]=0 and base[d]=cfg_offset for all d.
- **Start outside IDLE.** `start` in RUN is ignored.
- **Output in RUN.** `addr` = base[0]; `addr_valid` = 1.
- **Beat.** A beat is `addr_valid & addr_ready`. On a beat, let k be the lowest d with idx[d] != extent[d]-1.
  - idx[k]+1 and base[k] += stride[k].
  - For every j<k: idx[j]=0 and base[j]=new base[k].
- **Final beat.** If no such k exists, the beat is the final one: go to IDLE, pulse `done`, drop `addr_valid`.
- **Flags.**
  - `addr_last` = &dim_wrap (combinational from registered state).
  - `dim_wrap` bit d = AND over j≤d of (idx[j]==extent[j]-1).
  - `dim_wrap` is 0 outside RUN.
- **Arithmetic.** All address arithmetic is modulo 2^ADDR_W; negative strides and wrap past 0 or 2^ADDR_W are legal and simply wrap. There are no multipliers: base updates are adds only.
- **Extent 1.** A dimension with extent 1 always reports wrap and never increments.
- **abort.** In RUN: go to IDLE next cycle, `addr_valid` falls, no `done`, and a beat in the same cycle is discarded. In IDLE, `abort` is ignored.
- **start and abort together in IDLE.** `start` wins.
- **Total beats.** Product of the extents, up to 2^(DIMS*CNT_W).

## Timing
- **start → first valid.** `start` sampled high at edge t → `addr_valid`=1 with `addr`=cfg_offset after edge t.
- **Throughput.** One address per cycle while `addr_ready` is held high; no bubbles at dimension wraps.
- **Back-pressure.** While `addr_valid & !addr_ready`, `addr`, `addr_last` and `dim_wrap` are held stable.
- **done.** Asserted in the cycle after the final beat's edge, for exactly one cycle; `busy` falls on the same edge.
- **Back-to-back jobs.** A new `start` is accepted in the cycle `done` is high (state is IDLE); its first valid follows one cycle later.
- **rst.** Asserted at any time: outputs go to 0 immediately, asynchronously. The first `start` is accepted on the first edge after deassertion.
- **Registered outputs.** `addr`, `addr_valid`, `busy` and `done` are registered. `addr_last` and `dim_wrap` are combinational from registers only, never from `addr_ready`.

## Test plan
- **2-D raster, no back-pressure.** DIMS=2, offset=0x100, extents {x=3, y=2}, strides {x=1, y=16}, ready=1 → addrs 0x100, 0x101, 0x102, 0x110, 0x111, 0x112 on consecutive cycles. dim_wrap[0] on beats 3 and 6, addr_last on beat 6, then `done` one cycle later.
- **Back-pressure.** Same job with ready toggling 1,0,0,1,… → identical address sequence. addr and dim_wrap are stable during stalls, and the beat count is 6.
- **Negative stride and wrap-around.** offset=0x0001, x extent=4, stride=0xFFFF (-1) → 0x0001, 0x0000, 0xFFFF, 0xFFFE.
- **Empty and unit extents.** A start with extent y=0 → `done` one cycle later and addr_valid never high. Extents {1,1,1} → one beat at offset with addr_last=1 and dim_wrap=3'b111.
- **abort and reset mid-job.** Abort after 2 beats of a 3×3 job → IDLE next cycle with no `done`; a restart then gives a full, correct 9-beat sequence. A `rst` pulse mid-job forces all outputs to 0 asynchronously.
- **start while busy.** Pulse `start` during RUN with new cfg values → the running job is unaffected and the new cfg is not latched.
